// File: rtl/fp_norm_shift_pkg.sv
// Shared constants and types for the FP normalization shifter.
// Holds the field widths, the exponent range limits, the result word field
// offsets and the stage-1 pipeline payload struct.
package fp_norm_shift_pkg;

  localparam int COEF_W   = 48;
  localparam int EXP_W    = 15;
  localparam int SHIFT_W  = 6;
  localparam int RES_W    = 64;
  localparam int SIGN_BIT = 63;
  localparam int EXP_LSB  = 48;

  // Exponent adjust spans -63..+1, so one bit wider than the shift count.
  localparam int ADJ_W = SHIFT_W + 1;
  // Adjusted exponent: two extra bits so underflow (negative) and overflow
  // (above the 15-bit range) are both representable.
  localparam int E_W = EXP_W + 2;

  localparam logic [EXP_W-1:0] EXP_MIN = 15'o20000;
  localparam logic [EXP_W-1:0] EXP_MAX = 15'o57777;

  localparam logic signed [E_W-1:0] E_MIN = $signed({2'b00, EXP_MIN});
  localparam logic signed [E_W-1:0] E_MAX = $signed({2'b00, EXP_MAX});

  // Stage-1 payload: shifted coefficient plus the exponent bookkeeping
  // needed by the stage-2 exponent update.
  typedef struct packed {
    logic                    sign;
    logic [EXP_W-1:0]        exp;
    logic signed [ADJ_W-1:0] adj;
    logic [COEF_W-1:0]       coef;
  } s1_t;

  function automatic logic [RES_W-1:0] pack_result(
    input logic              sign,
    input logic [EXP_W-1:0]  exp,
    input logic [COEF_W-1:0] coef
  );
    logic [RES_W-1:0] r;
    r                       = '0;
    r[SIGN_BIT]             = sign;
    r[SIGN_BIT-1:EXP_LSB]   = exp;
    r[EXP_LSB-1:0]          = coef;
    return r;
  endfunction

endpackage

// File: rtl/fp_norm_shift_barrel.sv
// fp_norm_barrel: combinational normalization shifter (stage 1).
//   coef_in  : coefficient, bit COEF_W is the adder carry-out
//   shift    : leading-zero count {byte_index[2:0], zeros[2:0]}
//   coef_out : normalized COEF_W-bit coefficient
//   adj      : signed exponent adjustment (+1 on carry, else -shift)
module fp_norm_barrel
  import fp_norm_shift_pkg::*;
(
  input  logic [COEF_W:0]         coef_in,
  input  logic [SHIFT_W-1:0]      shift,
  output logic [COEF_W-1:0]       coef_out,
  output logic signed [ADJ_W-1:0] adj
);

  logic [COEF_W-1:0] byte_sh;

  always_comb begin
    // Two-level left shift: whole bytes first, then the residual 0..7 bits.
    byte_sh = coef_in[COEF_W-1:0] << {shift[5:3], 3'b000};
    if (coef_in[COEF_W]) begin
      // Carry-out: a single right shift renormalizes; the count is ignored.
      coef_out = coef_in[COEF_W:1];
      adj      = ADJ_W'(1);
    end else begin
      coef_out = byte_sh << shift[2:0];
      adj      = -$signed({1'b0, shift});
    end
  end

endmodule

// File: rtl/fp_norm_shift.sv
// fp_norm_shift: two-stage normalization of a sign/exponent/coefficient
// intermediate into a Cray-format 64-bit word.
//   Input side : i_valid/o_ready, i_sign, i_exp, i_coef (with carry), i_shift
//   Output side: o_valid/i_ready, o_result, o_underflow, o_overflow
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Stage 2 advances when it is empty or downstream is ready;
// stage 1 accepts when it is empty or is moving into stage 2 this cycle.
// The output payload and flags are registers and only change when stage 2
// advances with new data, so they hold while o_valid & !i_ready.
module fp_norm_shift
  import fp_norm_shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_sign,
  input  logic [EXP_W-1:0]   i_exp,
  input  logic [COEF_W:0]    i_coef,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [RES_W-1:0]   o_result,
  output logic               o_underflow,
  output logic               o_overflow
);

  s1_t  s1_d, s1_q;
  logic s1_full, s2_full;
  logic s2_adv;

  logic [COEF_W-1:0]       sh_coef;
  logic signed [ADJ_W-1:0] sh_adj;

  logic signed [E_W-1:0] e;
  logic [RES_W-1:0]      res_d;
  logic                  uf_d, of_d;

  fp_norm_barrel u_barrel (
    .coef_in  (i_coef),
    .shift    (i_shift),
    .coef_out (sh_coef),
    .adj      (sh_adj)
  );

  assign s1_d.sign = i_sign;
  assign s1_d.exp  = i_exp;
  assign s1_d.adj  = sh_adj;
  assign s1_d.coef = sh_coef;

  assign s2_adv  = !s2_full || i_ready;
  assign o_ready = !s1_full || s2_adv;
  assign o_valid = s2_full;

  // Stage 2 exponent update and range classification.
  always_comb begin
    e = $signed({2'b00, s1_q.exp})
      + $signed({{(E_W-ADJ_W){s1_q.adj[ADJ_W-1]}}, s1_q.adj});
    res_d = '0;
    uf_d  = 1'b0;
    of_d  = 1'b0;
    // A zero shifted coefficient covers both a zero operand and a count
    // large enough to shift every set bit out; neither raises a flag.
    if (s1_q.coef == '0) begin
      res_d = '0;
    end else if (e < E_MIN) begin
      uf_d = 1'b1;
    end else begin
      res_d = pack_result(s1_q.sign, e[EXP_W-1:0], s1_q.coef);
      of_d  = (e > E_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full     <= 1'b0;
      s2_full     <= 1'b0;
      s1_q        <= '0;
      o_result    <= '0;
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (o_ready) begin
        s1_full <= i_valid;
        if (i_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        s2_full <= s1_full;
        if (s1_full) begin
          o_result    <= res_d;
          o_underflow <= uf_d;
          o_overflow  <= of_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_shift.sv
// Testbench for fp_norm_shift: directed spec cases, random traffic with
// random back-pressure, a throttled back-to-back stream and a mid-stream
// reset. A negedge monitor scores every output against a reference model.
module tb_fp_norm_shift;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [14:0] i_exp;
  logic [48:0] i_coef;
  logic [5:0]  i_shift;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_result;
  logic        o_underflow;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;
  int occ = 0;
  int delivered = 0;

  // {result[63:0], underflow, overflow}
  logic [65:0] exp_q[$];

  fp_norm_shift dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sign      (i_sign),
    .i_exp       (i_exp),
    .i_coef      (i_coef),
    .i_shift     (i_shift),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_underflow (o_underflow),
    .o_overflow  (o_overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [65:0] model(input logic s, input logic [14:0] ex,
                                        input logic [48:0] c, input logic [5:0] sh);
    logic [111:0] wide;
    logic [47:0]  m;
    logic [14:0]  ef;
    int           ev;
    if (c[48]) begin
      m  = c[48:1];
      ev = int'(ex) + 1;
    end else begin
      wide = {64'b0, c[47:0]};
      wide = wide << sh;
      m    = wide[47:0];
      ev   = int'(ex) - int'(sh);
    end
    ef = 15'(ev);
    if (m == 48'b0) return 66'b0;
    if (ev < 8192) return {64'b0, 2'b10};
    if (ev > 24575) return {s, ef, m, 2'b01};
    return {s, ef, m, 2'b00};
  endfunction

  function automatic logic [5:0] lzc(input logic [47:0] c);
    for (int i = 47; i >= 0; i--) if (c[i]) return 6'(47 - i);
    return 6'd0;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic        acc;
    logic        del;
    logic [65:0] got;
    logic [65:0] want;
    if (rst) begin
      exp_q.delete();
      occ = 0;
    end else begin
      checks++;
      if (o_ready !== !(occ == 2 && !i_ready)) begin
        errors++;
        $display("FAIL o_ready: got %b, want %b (occupancy %0d, i_ready %b)",
                 o_ready, !(occ == 2 && !i_ready), occ, i_ready);
      end
      del = o_valid && i_ready;
      acc = i_valid && o_ready;
      if (del) begin
        delivered++;
        got = {o_result, o_underflow, o_overflow};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h, want no output", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL scoreboard: got result %h uf %b of %b, want result %h uf %b of %b",
                     got[65:2], got[1], got[0], want[65:2], want[1], want[0]);
          end
        end
      end
      if (acc) exp_q.push_back(model(i_sign, i_exp, i_coef, i_shift));
      occ = occ + int'(acc) - int'(del);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic s, input logic [14:0] ex,
                      input logic [48:0] c, input logic [5:0] sh);
    bit acc = 1'b0;
    i_sign = s; i_exp = ex; i_coef = c; i_shift = sh; i_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_accept: got no o_ready in 50 cycles, want acceptance");
    end
  endtask

  task automatic drain();
    i_ready = 1'b1;
    for (int k = 0; k < 40 && (exp_q.size() != 0 || o_valid); k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_sign = 1'b0; i_exp = '0; i_coef = '0; i_shift = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 5;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b, want 0", o_valid); end
    if (o_result !== 64'b0) begin errors++; $display("FAIL reset_o_result: got %h, want 0", o_result); end
    if (o_underflow !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b, want 0", o_underflow); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_of: got %b, want 0", o_overflow); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready: got %b, want 1", o_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    i_ready = 1'b1;
    i_sign = 1'b0; i_exp = 15'o40000; i_coef = 49'h1; i_shift = 6'd47; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL latency_1clk: got o_valid %b, want 0", o_valid); end
    @(posedge clk); #1;
    checks += 2;
    if (o_valid !== 1'b1) begin errors++; $display("FAIL latency_2clk: got o_valid %b, want 1", o_valid); end
    if (o_result !== {1'b0, 15'o37721, 48'h8000_0000_0000}) begin
      errors++;
      $display("FAIL latency_result: got %h, want %h", o_result, {1'b0, 15'o37721, 48'h8000_0000_0000});
    end
    drain();
  endtask

  task automatic test_directed();
    logic        t_s[11];
    logic [14:0] t_e[11];
    logic [48:0] t_c[11];
    logic [5:0]  t_sh[11];
    logic [63:0] t_r[11];
    logic [1:0]  t_f[11];
    bit          got;
    // shift >47 with nonzero coef and zero coef both give 0 with no flags
    t_s[0]  = 0; t_e[0]  = 15'o40000; t_c[0]  = 49'h1;                 t_sh[0]  = 47; t_r[0]  = {1'b0, 15'o37721, 48'h8000_0000_0000}; t_f[0]  = 2'b00;
    t_s[1]  = 1; t_e[1]  = 15'o40000; t_c[1]  = 49'h1_0000_0000_0000;  t_sh[1]  = 5;  t_r[1]  = {1'b1, 15'o40001, 48'h8000_0000_0000}; t_f[1]  = 2'b00;
    t_s[2]  = 0; t_e[2]  = 15'o20002; t_c[2]  = 49'h1;                 t_sh[2]  = 47; t_r[2]  = 64'b0;                                  t_f[2]  = 2'b10;
    t_s[3]  = 0; t_e[3]  = 15'o57777; t_c[3]  = 49'h1_2345_6789_ABCD;  t_sh[3]  = 0;  t_r[3]  = {1'b0, 15'o60000, 48'h91A2_B3C4_D5E6}; t_f[3]  = 2'b01;
    t_s[4]  = 1; t_e[4]  = 15'o12345; t_c[4]  = 49'h0;                 t_sh[4]  = 9;  t_r[4]  = 64'b0;                                  t_f[4]  = 2'b00;
    t_s[5]  = 0; t_e[5]  = 15'o40000; t_c[5]  = 49'h3;                 t_sh[5]  = 50; t_r[5]  = 64'b0;                                  t_f[5]  = 2'b00;
    t_s[6]  = 0; t_e[6]  = 15'o20005; t_c[6]  = 49'h0400_0000_0000;    t_sh[6]  = 5;  t_r[6]  = {1'b0, 15'o20000, 48'h8000_0000_0000}; t_f[6]  = 2'b00;
    t_s[7]  = 0; t_e[7]  = 15'o20004; t_c[7]  = 49'h0400_0000_0000;    t_sh[7]  = 5;  t_r[7]  = 64'b0;                                  t_f[7]  = 2'b10;
    t_s[8]  = 1; t_e[8]  = 15'o57777; t_c[8]  = 49'h8000_0000_0000;    t_sh[8]  = 0;  t_r[8]  = {1'b1, 15'o57777, 48'h8000_0000_0000}; t_f[8]  = 2'b00;
    t_s[9]  = 0; t_e[9]  = 15'o40000; t_c[9]  = 49'hAB_CDEF;           t_sh[9]  = 24; t_r[9]  = {1'b0, 15'o37750, 48'hABCD_EF00_0000}; t_f[9]  = 2'b00;
    t_s[10] = 1; t_e[10] = 15'o40000; t_c[10] = 49'hAB_CDEF;           t_sh[10] = 11; t_r[10] = {1'b1, 15'o37765, 48'h0005_5E6F_7800}; t_f[10] = 2'b00;
    i_ready = 1'b1;
    for (int n = 0; n < 11; n++) begin
      send(t_s[n], t_e[n], t_c[n], t_sh[n]);
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
        @(negedge clk);
        got = o_valid;
      end
      checks += 3;
      if (!got) begin
        errors++;
        $display("FAIL directed_%0d_valid: got no o_valid in 6 cycles, want o_valid", n);
      end
      if (o_result !== t_r[n]) begin
        errors++;
        $display("FAIL directed_%0d_result: got %h, want %h", n, o_result, t_r[n]);
      end
      if ({o_underflow, o_overflow} !== t_f[n]) begin
        errors++;
        $display("FAIL directed_%0d_flags: got uf/of %b, want %b", n, {o_underflow, o_overflow}, t_f[n]);
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_random();
    int          accepted = 0;
    logic [63:0] r;
    for (int cyc = 0; cyc < 2000 && accepted < 60; cyc++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_sign  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: i_exp = 15'o20000 + 15'($urandom_range(0, 60));
        1: i_exp = 15'o57777 - 15'($urandom_range(0, 3));
        2: i_exp = 15'($urandom());
        default: i_exp = 15'o40000;
      endcase
      r = {$urandom(), $urandom()};
      i_coef = {($urandom_range(0, 3) == 0), r[47:0] >> $urandom_range(0, 47)};
      if ($urandom_range(0, 1) == 1) i_shift = lzc(i_coef[47:0]);
      else                           i_shift = 6'($urandom_range(0, 63));
      @(negedge clk);
      if (i_valid && o_ready) accepted++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    checks++;
    if (accepted != 60) begin
      errors++;
      $display("FAIL random_accept: got %0d accepted, want 60", accepted);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int d0   = delivered;
    for (int cyc = 0; cyc < 200 && sent < 8; cyc++) begin
      i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      i_valid = 1'b1;
      i_sign  = sent[0];
      i_exp   = 15'o40000 + 15'(sent);
      i_coef  = 49'h0000_0100_0000 << sent;
      i_shift = lzc(i_coef[47:0]);
      @(negedge clk);
      if (o_ready) sent++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    drain();
    checks++;
    if (delivered - d0 != 8) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d outputs, want 8", delivered - d0);
    end
  endtask

  task automatic test_reset_midstream();
    int d0;
    i_ready = 1'b0;
    send(1'b0, 15'o40000, 49'h1234, 6'd35);
    send(1'b1, 15'o40010, 49'h5678, 6'd33);
    checks++;
    if (o_valid !== 1'b1) begin errors++; $display("FAIL midrst_inflight: got o_valid %b, want 1", o_valid); end
    d0 = delivered;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_o_valid: got %b, want 0", o_valid); end
    rst = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_o_ready: got %b, want 1", o_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (delivered != d0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_discard: got %0d outputs o_valid %b, want 0 outputs o_valid 0",
               delivered - d0, o_valid);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
